stream_framer: RTL and testbench
================================

Name: stream_framer

Overview:
- Sits directly downstream of the block-RAM FIFO and consumes its unregistered valid/ready output stream.
- Groups payload words into fixed-length frames and emits each frame on a registered valid/ready output.
- Frame format: SYNC word, sequence number, FRAME_LEN payload words, then a modulo-2^WIDTH checksum word.
- Its registered output breaks the combinational RAM-read path before the link/serializer stage.

Parameters:
- WIDTH, 8, data width of input and output words (>=4).
- FRAME_LEN, 16, payload words per frame (>=1).
- SYNC_WORD, 8'hA5, first word of every frame (WIDTH bits).

Ports:
- i_clock  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_in_data  input  WIDTH  payload word from the FIFO.
- i_in_valid  input  1  payload word available.
- o_in_ready  output  1  payload word accepted this cycle when high together with i_in_valid.
- o_out_data  output  WIDTH  registered frame word.
- o_out_valid  output  1  o_out_data valid.
- o_out_first  output  1  high with the SYNC word.
- o_out_last  output  1  high with the checksum word.
- i_out_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset values:
  - o_out_valid=0, o_out_first=0, o_out_last=0, o_out_data=0.
  - state=ST_IDLE, seq=0, csum=0, count=0.
  - o_in_ready=0 during reset.
- Reset asserted mid-frame discards the partial frame. No checksum is emitted. The sequence returns to 0.
- Output register:
  - load_en = !o_out_valid || i_out_ready.
  - When a word loads, o_out_valid=1 next cycle.
  - When i_out_ready=1 and nothing loads, o_out_valid=0 next cycle.
  - o_out_data, o_out_first and o_out_last hold while o_out_valid && !i_out_ready.
- o_in_ready = (state==ST_PAYLOAD) && load_en. This is combinational from i_out_ready and state. There is no path from i_in_valid to o_in_ready.
- State machine:
  - ST_IDLE: no input consumed. If i_in_valid && load_en, load SYNC_WORD with first=1, then go to ST_SEQ. A frame is started only once payload is present.
  - ST_SEQ: if load_en, load seq, clear count, go to ST_PAYLOAD.
  - ST_PAYLOAD: on an input handshake, load i_in_data, csum <= csum + i_in_data (WIDTH bits, carry dropped), count++. If count==FRAME_LEN-1 at the handshake, go to ST_CSUM.
  - ST_CSUM: if load_en, load csum with last=1, csum<=0, seq<=seq+1 (wraps at 2^WIDTH), go to ST_IDLE.
- The checksum covers payload words only; SYNC and seq are excluded.
- Counter width is $clog2(FRAME_LEN+1). When FRAME_LEN=1, ST_PAYLOAD lasts one handshake.
- Input starvation in ST_PAYLOAD stalls the frame indefinitely. There is no timeout and no padding.
- Latency: the SYNC word appears on the output 1 cycle after the first cycle in ST_IDLE with i_in_valid=1.
- Throughput: with i_in_valid=1 and i_out_ready=1 continuously, one word is output per cycle. A frame takes FRAME_LEN+3 cycles.
- ST_IDLE returns to ST_SYNC emission the cycle after the checksum is loaded, if input is valid.
- Simultaneous events: in the same cycle, the output register may drain (i_out_ready) and reload (load_en=1); the new word replaces the old one.

Decomposition:
- Package framer_pkg:
  - state enum (ST_IDLE, ST_SEQ, ST_PAYLOAD, ST_CSUM).
  - default SYNC constant.
  - helper function for the count width.
- Sub-module stream_out_reg (parameter WIDTH+2):
  - single-entry valid/ready output register carrying {first, last, data}.
  - exposes load_en to the framer FSM.

Test Plan (WIDTH=8, FRAME_LEN=4):
1. Input 01,02,03,04 with ready always 1 -> output A5(first),00,01,02,03,04,0A(last) on 7 consecutive cycles; o_in_ready high for exactly 4 cycles.
2. Two back-to-back frames with payload 10,20,30,40 then 01,01,01,01 -> second frame is A5,01,01,01,01,01,04; seq advances from 00 to 01.
3. Checksum overflow: payload FF,FF,FF,FF -> checksum word FC.
4. Backpressure: i_out_ready toggles 1,0,0,1,... throughout -> every word held stable while stalled; no duplicated or lost words; o_in_ready=0 on every stalled cycle.
5. Starvation: i_in_valid drops after 2 payload words for 10 cycles -> o_out_valid goes low after draining; frame resumes and completes with the correct checksum; no padding words.
6. Reset asserted after the 2nd payload word, then a fresh frame 05,06,07,08 -> no checksum is emitted for the partial frame; next frame is A5,00,05,06,07,08,1A; all outputs are 0 during reset.

Source files
------------

// File: rtl/framer_pkg.sv
// framer_pkg: shared state encoding, default sync word and counter sizing for stream_framer
package framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEQ     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

    function automatic int count_w(input int frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: single-entry valid/ready output register; refills in the same cycle it drains
module stream_out_reg #(
    parameter int W = 10
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_load_en,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic w_load;

    assign o_load_en = !o_valid || i_ready;
    assign w_load    = i_load && o_load_en;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (w_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_framer.sv
// stream_framer: wraps payload words into SYNC/seq/payload/checksum frames behind a registered output
module stream_framer
    import framer_pkg::*;
#(
    parameter int                   WIDTH     = 8,
    parameter int                   FRAME_LEN = 16,
    parameter logic [WIDTH-1:0]     SYNC_WORD = WIDTH'(DEFAULT_SYNC)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_out_first,
    output logic             o_out_last,
    input  logic             i_out_ready
);

    localparam int CW = count_w(FRAME_LEN);

    state_t             r_state;
    logic [WIDTH-1:0]   r_seq;
    logic [WIDTH-1:0]   r_csum;
    logic [CW-1:0]      r_count;
    logic               w_load_en;
    logic               w_load;
    logic               w_hs;
    logic               w_last_payload;
    logic [WIDTH+1:0]   w_word;
    logic [WIDTH+1:0]   w_out;

    // in_ready depends only on state and downstream space, never on i_in_valid
    assign o_in_ready     = !i_reset && (r_state == ST_PAYLOAD) && w_load_en;
    assign w_hs           = o_in_ready && i_in_valid;
    assign w_last_payload = r_count == CW'(FRAME_LEN - 1);

    always_comb begin
        w_load = 1'b0;
        w_word = '0;
        case (r_state)
            ST_IDLE: begin
                w_load = i_in_valid && w_load_en;
                w_word = {2'b10, SYNC_WORD};
            end
            ST_SEQ: begin
                w_load = w_load_en;
                w_word = {2'b00, r_seq};
            end
            ST_PAYLOAD: begin
                w_load = w_hs;
                w_word = {2'b00, i_in_data};
            end
            default: begin
                w_load = w_load_en;
                w_word = {2'b01, r_csum};
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_seq   <= '0;
            r_csum  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load)
                        r_state <= ST_SEQ;
                end
                ST_SEQ: begin
                    if (w_load_en) begin
                        r_count <= '0;
                        r_state <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_hs) begin
                        r_csum  <= r_csum + i_in_data;
                        r_count <= r_count + 1'b1;
                        if (w_last_payload)
                            r_state <= ST_CSUM;
                    end
                end
                default: begin
                    if (w_load_en) begin
                        r_csum  <= '0;
                        r_seq   <= r_seq + 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    stream_out_reg #(
        .W(WIDTH + 2)
    ) u_out_reg (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_data    (w_word),
        .o_load_en (w_load_en),
        .o_data    (w_out),
        .o_valid   (o_out_valid),
        .i_ready   (i_out_ready)
    );

    assign {o_out_first, o_out_last, o_out_data} = w_out;

endmodule

// File: tb/tb_stream_framer.sv
// tb_stream_framer: scoreboard bench; expected frames are built from the pushed payload list
module tb_stream_framer;

    localparam int         FL   = 4;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       i_clock     = 1'b0;
    logic       i_reset     = 1'b1;
    logic [7:0] i_in_data   = 8'h00;
    logic       i_in_valid  = 1'b0;
    logic       i_out_ready = 1'b0;
    logic       o_in_ready;
    logic [7:0] o_out_data;
    logic       o_out_valid;
    logic       o_out_first;
    logic       o_out_last;

    stream_framer #(
        .WIDTH     (8),
        .FRAME_LEN (FL),
        .SYNC_WORD (SYNC)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_in_data   (i_in_data),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_out_data  (o_out_data),
        .o_out_valid (o_out_valid),
        .o_out_first (o_out_first),
        .o_out_last  (o_out_last),
        .i_out_ready (i_out_ready)
    );

    always #5 i_clock = ~i_clock;

    int n_total = 0, n_bad = 0, cyc = 0;
    int vprob = 100, rprob = 100;
    bit rmode = 1'b0;

    logic [7:0] q_in[$];
    logic [9:0] q_exp[$];
    logic [7:0] m_seq = 8'h00, m_sum = 8'h00;
    int         m_cnt = 0;

    int         n_inrdy, n_in, first_out, last_out;
    logic [7:0] last_csum, seq_seen;
    bit         after_first, prev_stall = 1'b0;
    logic [9:0] prev_word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // a frame is the next FL payload words in push order, framed with sync, seq and their sum
    task automatic push(input logic [7:0] d);
        if (m_cnt == 0) begin
            q_exp.push_back({2'b10, SYNC});
            q_exp.push_back({2'b00, m_seq});
        end
        q_exp.push_back({2'b00, d});
        m_sum = m_sum + d;
        m_cnt++;
        if (m_cnt == FL) begin
            q_exp.push_back({2'b01, m_sum});
            m_sum = 8'h00;
            m_cnt = 0;
            m_seq = m_seq + 8'h01;
        end
        q_in.push_back(d);
    endtask

    task automatic phase_clr();
        n_inrdy = 0; n_in = 0; first_out = -1; last_out = -1;
        last_csum = 8'h00; seq_seen = 8'hEE; after_first = 1'b0;
    endtask

    task automatic step();
        logic [9:0] w, e;
        @(posedge i_clock);
        #1;
        cyc++;
        i_in_valid  = (q_in.size() > 0) && ($urandom_range(99) < 32'(vprob));
        i_in_data   = (q_in.size() > 0) ? q_in[0] : 8'($urandom);
        i_out_ready = rmode ? (cyc % 3 == 0) : ($urandom_range(99) < 32'(rprob));
        #4;
        w = {o_out_first, o_out_last, o_out_data};
        if (i_reset) begin
            chk("reset_outputs", 32'({o_in_ready, o_out_valid, w}), 32'h0);
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 32'({o_out_valid, w}), 32'({1'b1, prev_word}));
            if (o_out_valid && !i_out_ready)
                chk("stall_in_ready", 32'(o_in_ready), 32'h0);
            if (o_in_ready) n_inrdy++;
            if (i_in_valid && o_in_ready) begin
                void'(q_in.pop_front());
                n_in++;
            end
            if (o_out_valid && i_out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("extra_word", 32'h0, 32'h1);
                end else begin
                    e = q_exp.pop_front();
                    chk("out_word", 32'(w), 32'(e));
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                if (after_first) seq_seen = o_out_data;
                after_first = o_out_first;
                if (o_out_last) last_csum = o_out_data;
            end
            prev_stall = o_out_valid && !i_out_ready;
            prev_word  = w;
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        q_in.delete();
        q_exp.delete();
        m_seq = 8'h00; m_sum = 8'h00; m_cnt = 0;
        step();
        step();
        i_reset = 1'b0;
        prev_stall = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while ((q_exp.size() > 0 || q_in.size() > 0) && b < 4000) begin
            step();
            b++;
        end
        chk("drain", 32'(q_exp.size() + q_in.size()), 32'h0);
    endtask

    initial begin
        int b;
        do_reset();

        phase_clr();
        for (int i = 1; i <= 4; i++) push(8'(i));
        drain();
        chk("t1_span", 32'(last_out - first_out), 32'd6);
        chk("t1_in_ready_cycles", 32'(n_inrdy), 32'd4);
        chk("t1_csum", 32'(last_csum), 32'h0A);
        chk("t1_seq", 32'(seq_seen), 32'h00);

        do_reset();
        phase_clr();
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        for (int i = 0; i < 4; i++) push(8'h01);
        drain();
        chk("t2_span", 32'(last_out - first_out), 32'd13);
        chk("t2_seq", 32'(seq_seen), 32'h01);
        chk("t2_csum", 32'(last_csum), 32'h04);

        phase_clr();
        for (int i = 0; i < 4; i++) push(8'hFF);
        drain();
        chk("t3_csum", 32'(last_csum), 32'hFC);

        phase_clr();
        rmode = 1'b1;
        for (int i = 0; i < 2 * FL; i++) push(8'($urandom));
        drain();
        rmode = 1'b0;

        phase_clr();
        push(8'h11); push(8'h22);
        b = 0;
        while (q_in.size() > 0 && b < 100) begin step(); b++; end
        repeat (10) step();
        chk("t5_drained_valid", 32'(o_out_valid), 32'h0);
        push(8'h33); push(8'h44);
        drain();
        chk("t5_csum", 32'(last_csum), 32'hAA);

        phase_clr();
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        b = 0;
        while (n_in < 2 && b < 100) begin step(); b++; end
        chk("t6_partial", 32'(n_in), 32'd2);
        step();
        do_reset();
        phase_clr();
        for (int i = 5; i <= 8; i++) push(8'(i));
        drain();
        chk("t6_seq", 32'(seq_seen), 32'h00);
        chk("t6_csum", 32'(last_csum), 32'h1A);

        phase_clr();
        vprob = 60; rprob = 60;
        for (int i = 0; i < 25 * FL; i++) push(8'($urandom));
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
